// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state type and byte-lane geometry of the 32-bit data word.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
// Load path: picks the byte/halfword lane from the fetched word and
// sign- or zero-extends it. Store path: merges the store data into the
// previously read word so sub-word stores become full-word writes.
// Halfword lane is chosen by addr[1] only; word and reserved sizes use the
// whole word, so low address bits are ignored for those.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] ld_word_i,
    input  logic [31:0] st_old_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [7:0]  merged [NUM_LANES];

    assign ld_byte = ld_word_i[{addr_lo_i, 3'b000} +: 8];
    assign ld_half = ld_word_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Extend the selected lane according to access size and signedness.
    always_comb begin
        ld_data_o = ld_word_i;
        case (size_i)
            SZ_BYTE: ld_data_o = uns_i ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_o = uns_i ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

    // Per-lane store merge: a lane takes new data only if the access covers it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE_IDX = 2'(gi);
            assign merged[gi] =
                (size_i == SZ_BYTE) ?
                    ((addr_lo_i == LANE_IDX) ? st_wdata_i[7:0] : st_old_i[LANE_W*gi +: LANE_W]) :
                (size_i == SZ_HALF) ?
                    ((addr_lo_i[1] == LANE_IDX[1]) ? st_wdata_i[LANE_W*(gi%2) +: LANE_W]
                                                   : st_old_i[LANE_W*gi +: LANE_W]) :
                    st_wdata_i[LANE_W*gi +: LANE_W];
        end
    endgenerate

    assign st_word_o = {merged[3], merged[2], merged[1], merged[0]};

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-addressed data memory.
// Requests arrive over valid/ready, responses leave over valid/ready.
// Sub-word stores are done as read-modify-write (RD then WR).
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses and the reserved size answer immediately with rsp_err=1
// and touch no memory; when undefined, rsp_err is tied low.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] ld_data_d;
    logic [DATA_W-1:0] st_word_d;

`ifdef LSU_MISALIGN_TRAP_EN
    logic rsp_err_q;
    logic misalign_d;

    // Misaligned half/word or reserved size in the incoming request.
    assign misalign_d = (req_size == SZ_RSVD) ||
                        ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    lsu_align u_align (
        .size_i     (size_q),
        .uns_i      (uns_q),
        .addr_lo_i  (addr_q[1:0]),
        .ld_word_i  (mem_read_data),
        .st_old_i   (rdata_q),
        .st_wdata_i (wdata_q),
        .ld_data_o  (ld_data_d),
        .st_word_o  (st_word_d)
    );

    // Request/response FSM; all latched request and response state lives here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign_d) begin
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end else
`endif
                        // size[1] set means word (reserved size behaves as word)
                        if (req_we && req_size[1]) begin
                            state_q <= ST_WR;
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    rdata_q <= mem_read_data;
                    if (we_q) begin
                        state_q <= ST_WR;
                    end else begin
                        state_q     <= ST_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ld_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
                        rsp_err_q   <= 1'b0;
`endif
                    end
                end
                ST_WR: begin
                    state_q     <= ST_RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    rsp_err_q   <= 1'b0;
`endif
                end
                default: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Memory strobes are gated by reset so an interrupted RMW never writes.
    assign req_ready      = (state_q == ST_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign mem_read       = (state_q == ST_RD) && !reset;
    assign mem_write      = (state_q == ST_WR) && !reset;
    assign mem_address    = ((state_q == ST_RD) || (state_q == ST_WR)) ?
                            {2'b00, addr_q[ADDR_W-1:2]} : '0;
    assign mem_write_data = (state_q == ST_WR) ? st_word_d : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 16-word behavioural memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [16];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[3:0]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[3:0]] <= mem_write_data;
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (mem_read)  rd_cnt <= rd_cnt + 1;
    end

    // One complete transaction; lat counts clock edges from accept to rsp_valid.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic err);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1 addr=%h", rsp_valid, addr);
        end
        rd = rsp_rdata; err = rsp_err;
        $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d",
                 we, sz, uns, addr, wd, lat, rd, err);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata: got %h required 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err: got %b required 0", rsp_err); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b required 00", {mem_read, mem_write}); end
        $display("reset done");
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic err; int r0;
        r0 = rd_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, lat, rd, err);
        checks++; if (lat != 2) begin failures++; $display("FAIL word_store_lat: got %0d required 2", lat); end
        checks++; if (mem[2] !== 32'hDEADBEEF) begin failures++; $display("FAIL word_store_mem: got %h required deadbeef", mem[2]); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL word_store_rdata: got %h required 0", rd); end
        checks++; if (rd_cnt != r0) begin failures++; $display("FAIL word_store_noread: reads %0d required %0d", rd_cnt, r0); end
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, err);
        checks++; if (lat != 2) begin failures++; $display("FAIL word_load_lat: got %0d required 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load_data: got %h required deadbeef", rd); end
    endtask

    task automatic test_byte_rmw();
        int lat; logic [31:0] rd; logic err; int r0; int w0;
        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, lat, rd, err);
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h6, 32'h123456AA, lat, rd, err);
        checks++; if (lat != 3) begin failures++; $display("FAIL byte_rmw_lat: got %0d required 3", lat); end
        checks++; if (mem[1] !== 32'h11AA3344) begin failures++; $display("FAIL byte_rmw_mem: got %h required 11aa3344", mem[1]); end
        checks++; if ((rd_cnt - r0) != 1 || (wr_cnt - w0) != 1) begin failures++; $display("FAIL byte_rmw_strobes: reads %0d writes %0d required 1 1", rd_cnt - r0, wr_cnt - w0); end
        // halfword store into upper half of word[3]
        do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'h80017F80, lat, rd, err);
        do_req(1'b1, 2'b01, 1'b0, 32'hE, 32'h0000BEEF, lat, rd, err);
        checks++; if (mem[3] !== 32'hBEEF7F80) begin failures++; $display("FAIL half_rmw_mem: got %h required beef7f80", mem[3]); end
    endtask

    task automatic test_extend();
        int lat; logic [31:0] rd; logic err;
        do_req(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'hFFFFFFAA) begin failures++; $display("FAIL ld_byte_s: got %h required ffffffaa", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'h000000AA) begin failures++; $display("FAIL ld_byte_u: got %h required 000000aa", rd); end
        do_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'h00003344) begin failures++; $display("FAIL ld_half_s_lo: got %h required 00003344", rd); end
        do_req(1'b0, 2'b01, 1'b0, 32'hE, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'hFFFFBEEF) begin failures++; $display("FAIL ld_half_s_hi: got %h required ffffbeef", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'hE, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'h0000BEEF) begin failures++; $display("FAIL ld_half_u_hi: got %h required 0000beef", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'hC, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL ld_byte_s_lane0: got %h required ffffff80", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'hD, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'h0000007F) begin failures++; $display("FAIL ld_byte_s_lane1: got %h required 0000007f", rd); end
    endtask

    task automatic test_backpressure();
        int r0; int w0; int wait_cyc; logic [31:0] first;
        logic [31:0] mem0_before;
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h0BADF00D, wait_cyc, first, mem0_before[0]);
        mem0_before = mem[0];
        r0 = rd_cnt; w0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h8; req_wdata = 32'h0;
        @(posedge clk); #1;
        // a competing store is held on the request port while the response waits
        req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
        wait_cyc = 0;
        while (!rsp_valid && wait_cyc < 20) begin @(posedge clk); #1; wait_cyc++; end
        first = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: valid=%b rdata=%h ready=%b required 1 deadbeef 0", i, rsp_valid, rsp_rdata, req_ready);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("txn backpressure load addr=00000008 -> rdata=%h", first);
        checks++; if ((rd_cnt - r0) != 1) begin failures++; $display("FAIL bp_one_read: reads %0d required 1", rd_cnt - r0); end
        checks++; if (wr_cnt != w0 || mem[0] !== mem0_before) begin failures++; $display("FAIL bp_no_accept: mem0=%h writes %0d required %h %0d", mem[0], wr_cnt - w0, mem0_before, 0); end
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release: ready=%b valid=%b required 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_mid_wr();
        int w0;
        w0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h4; req_wdata = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (mem_read !== 1'b1 || mem_address !== 32'h1) begin failures++; $display("FAIL rmw_rd_phase: rd=%b addr=%h required 1 00000001", mem_read, mem_address); end
        @(posedge clk); #1;
        checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL rmw_wr_phase: wr=%b required 1", mem_write); end
        reset = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rst_wr_gate: wr=%b required 0", mem_write); end
        @(posedge clk); #1;
        reset = 1'b0;
        $display("txn reset during sub-word store WR -> word1=%h", mem[1]);
        checks++; if (mem[1] !== 32'h11AA3344 || wr_cnt != w0) begin failures++; $display("FAIL rst_mem_kept: word1=%h writes %0d required 11aa3344 0", mem[1], wr_cnt - w0); end
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_idle: ready=%b valid=%b required 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd; logic err; int r0; int w0;
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h5, 32'h0, lat, rd, err);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (lat != 1 || err !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL mis_word_trap: lat=%0d err=%b rdata=%h required 1 1 0", lat, err, rd); end
        checks++; if (rd_cnt != r0 || wr_cnt != w0) begin failures++; $display("FAIL mis_no_strobe: reads %0d writes %0d required 0 0", rd_cnt - r0, wr_cnt - w0); end
        do_req(1'b1, 2'b11, 1'b0, 32'h4, 32'h12345678, lat, rd, err);
        checks++; if (err !== 1'b1 || mem[1] !== 32'h11AA3344) begin failures++; $display("FAIL mis_rsvd_trap: err=%b word1=%h required 1 11aa3344", err, mem[1]); end
`else
        checks++; if (lat != 2 || err !== 1'b0 || rd !== 32'h11AA3344) begin failures++; $display("FAIL mis_word_lane0: lat=%0d err=%b rdata=%h required 2 0 11aa3344", lat, err, rd); end
        checks++; if ((rd_cnt - r0) != 1) begin failures++; $display("FAIL mis_one_read: reads %0d required 1", rd_cnt - r0); end
        do_req(1'b0, 2'b01, 1'b1, 32'h7, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'h000011AA) begin failures++; $display("FAIL mis_half_addr1: got %h required 000011aa", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_rmw();
        test_extend();
        test_backpressure();
        test_reset_mid_wr();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
